// File: rtl/axi_wr_pkg.sv
// Shared codes and types for the AXI write slave: burst/response encodings and FSM states.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wr_slave_if.sv
// AXI write channels (AW, W, B) between a master and the write slave.
interface axi_wr_slave_if #(
  parameter int ID_W   = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts; oversize beats step by the full bus width.
module axi_burst_addr
  import axi_wr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  logic [2:0]        eff_size;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    eff_size  = (size > MAX_SIZE) ? MAX_SIZE : size;
    step      = ADDR_W'(1) << eff_size;
    incr      = addr + step;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << eff_size) - ADDR_W'(1);
    // An illegal WRAP length has no power-of-two window, so it walks like INCR.
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_len_ok(len) ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : incr;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI write slave: accepts one AW, streams its beats to a memory
// write port with one cycle of latency, then returns a B response.
//   state   | meaning
//   IDLE    | waiting for AW, awready high
//   DATA    | accepting W beats until beat count reaches len
//   RESP    | holding B response until bready
module axi_wr_slave
  import axi_wr_pkg::*;
#(
  parameter int ID_W   = 12,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  axi_wr_slave_if.slave       s_axi,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  state_e            state;
  state_e            state_nxt;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              aw_hs;
  logic              w_hs;
  logic              last_beat;
  logic              aw_err;
  logic              beat_err;

  assign aw_hs     = s_axi.awvalid & s_axi.awready;
  assign w_hs      = s_axi.wvalid & s_axi.wready;
  assign last_beat = (cnt_q == len_q);
  assign aw_err    = (s_axi.awsize > MAX_SIZE) || (s_axi.awburst == BURST_RSVD) ||
                     ((s_axi.awburst == BURST_WRAP) && !wrap_len_ok(s_axi.awlen));
  assign beat_err  = (s_axi.wid != id_q) || (s_axi.wlast != last_beat);

  axi_burst_addr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Completion follows the beat count; a misplaced wlast only flags an error.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (s_axi.awvalid)             state_nxt = ST_DATA;
      ST_DATA: if (s_axi.wvalid && last_beat) state_nxt = ST_RESP;
      ST_RESP: if (s_axi.bready)              state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = (state == ST_IDLE);
    s_axi.wready  = (state == ST_DATA);
    s_axi.bvalid  = (state == ST_RESP);
    s_axi.bid     = (state == ST_RESP) ? id_q : '0;
    s_axi.bresp   = (state == ST_RESP) ? (err_q ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      if (aw_hs) begin
        id_q    <= s_axi.awid;
        addr_q  <= s_axi.awaddr;
        len_q   <= s_axi.awlen;
        size_q  <= s_axi.awsize;
        burst_q <= s_axi.awburst;
        cnt_q   <= '0;
        err_q   <= aw_err;
      end
      if (w_hs) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr_q;
        mem_wdata <= s_axi.wdata;
        mem_wstrb <= s_axi.wstrb;
        addr_q    <= addr_nxt;
        cnt_q     <= cnt_q + 8'd1;
        err_q     <= err_q | beat_err;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Scoreboard bench for axi_wr_slave: directed scenarios plus randomized bursts.
module tb_axi_wr_slave;
  import axi_wr_pkg::*;

  localparam int ID_W   = 12;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  always #5 clk = ~clk;

  axi_wr_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_axi ();

  axi_wr_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (s_axi),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } mem_exp_t;

  typedef struct {
    logic [11:0] id;
    logic [1:0]  resp;
  } b_exp_t;

  mem_exp_t mem_q[$];
  b_exp_t   b_q[$];
  int       checks   = 0;
  int       failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Reference address: beat i of a burst, computed directly from the burst rules.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst,
                                             input int i);
    int unsigned step;
    logic [31:0] win, base, off;
    step = (size > 3) ? 8 : (1 << size);
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      win  = (32'(len) + 1) * step;
      base = start - (start % win);
      off  = (start - base + 32'(i) * step) % win;
      return base + off;
    end
    return start + 32'(i) * step;
  endfunction

  function automatic bit model_static_err(input logic [2:0] size, input logic [1:0] burst,
                                          input logic [7:0] len);
    return (size > 3) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Monitor: compares every memory write and every B handshake against the queues.
  always @(negedge clk) begin
    mem_exp_t me;
    b_exp_t   be;
    if (mem_we) begin
      if (mem_q.size() == 0) begin
        timeout_fail("unexpected_mem_we");
      end else begin
        me = mem_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(me.addr));
        chk("mem_wdata", mem_wdata, me.data);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(me.strb));
      end
    end
    if (s_axi.bvalid && s_axi.bready) begin
      if (b_q.size() == 0) begin
        timeout_fail("unexpected_bresp");
      end else begin
        be = b_q.pop_front();
        chk("bid", 64'(s_axi.bid), 64'(be.id));
        chk("bresp", 64'(s_axi.bresp), 64'(be.resp));
      end
    end
  end

  // which: 0 awready, 1 wready (both complete the handshake edge), 2 bvalid (returns at negedge)
  task automatic wait_ready(input int which, output bit ok);
    logic r;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      r = (which == 0) ? s_axi.awready : ((which == 1) ? s_axi.wready : s_axi.bvalid);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail($sformatf("wait_%0d", which));
    if (ok && which < 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_txn(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int bad_wid_beat,
                         input int wlast_beat, input int bdelay, input int rst_after,
                         input bit early_w, input bit gaps);
    bit          ok;
    bit          err;
    int          g;
    logic [63:0] data[256];
    logic [7:0]  strb[256];
    logic [1:0]  exp_resp;
    for (int i = 0; i <= int'(len); i++) begin
      data[i] = {$urandom, $urandom};
      strb[i] = 8'($urandom);
    end
    err = model_static_err(size, burst, len);
    if (early_w) begin
      s_axi.wid    = (bad_wid_beat == 0) ? (id ^ 12'h1) : id;
      s_axi.wdata  = data[0];
      s_axi.wstrb  = strb[0];
      s_axi.wlast  = (wlast_beat == 0);
      s_axi.wvalid = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk("w_stall_before_aw", 64'(s_axi.wready), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    s_axi.awid    = id;
    s_axi.awaddr  = addr;
    s_axi.awlen   = len;
    s_axi.awsize  = size;
    s_axi.awburst = burst;
    s_axi.awvalid = 1'b1;
    wait_ready(0, ok);
    s_axi.awvalid = 1'b0;
    if (!ok) begin
      s_axi.wvalid = 1'b0;
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      if (i == rst_after) begin
        s_axi.wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_wready", 64'(s_axi.wready), 64'd0);
        chk("rst_bvalid", 64'(s_axi.bvalid), 64'd0);
        chk("rst_bid", 64'(s_axi.bid), 64'd0);
        chk("rst_awready", 64'(s_axi.awready), 64'd1);
        rst = 1'b0;
        return;
      end
      if (gaps && !(early_w && i == 0)) begin
        g = int'($urandom_range(0, 2));
        if (g > 0) begin
          s_axi.wvalid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      s_axi.wid    = (i == bad_wid_beat) ? (id ^ 12'h1) : id;
      s_axi.wdata  = data[i];
      s_axi.wstrb  = strb[i];
      s_axi.wlast  = (i == wlast_beat);
      s_axi.wvalid = 1'b1;
      wait_ready(1, ok);
      if (!ok) begin
        s_axi.wvalid = 1'b0;
        return;
      end
      mem_q.push_back('{model_addr(addr, size, len, burst, i), data[i], strb[i]});
      if ((i == bad_wid_beat) || ((i == wlast_beat) != (i == int'(len)))) err = 1'b1;
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    exp_resp = err ? 2'b10 : 2'b00;
    b_q.push_back('{id, exp_resp});
    wait_ready(2, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    for (int k = 0; k < bdelay; k++) begin
      chk("hold_bvalid", 64'(s_axi.bvalid), 64'd1);
      chk("hold_bid", 64'(s_axi.bid), 64'(id));
      chk("hold_bresp", 64'(s_axi.bresp), 64'(exp_resp));
      chk("hold_awready", 64'(s_axi.awready), 64'd0);
      chk("hold_wready", 64'(s_axi.wready), 64'd0);
      @(posedge clk);
      #1;
    end
    s_axi.bready = 1'b1;
    @(posedge clk);
    #1;
    s_axi.bready = 1'b0;
  endtask

  initial begin
    logic [7:0] len;
    logic [1:0] burst;
    s_axi.awid = '0;  s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0;
    s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wid = '0;   s_axi.wdata = '0;  s_axi.wstrb = '0; s_axi.wlast = 1'b0;
    s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_awready", 64'(s_axi.awready), 64'd1);
    chk("reset_wready", 64'(s_axi.wready), 64'd0);
    chk("reset_bvalid", 64'(s_axi.bvalid), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_txn(12'h5A5, 32'h1000, 8'd3, 3'd3, BURST_INCR,  -1, 3, 0, -1, 1'b0, 1'b0);
    run_txn(12'h123, 32'h1018, 8'd3, 3'd3, BURST_WRAP,  -1, 3, 0, -1, 1'b0, 1'b0);
    run_txn(12'h0F0, 32'h0040, 8'd1, 3'd3, BURST_FIXED,  1, 1, 0, -1, 1'b0, 1'b0);
    run_txn(12'h777, 32'h2000, 8'd2, 3'd3, BURST_INCR,  -1, 1, 0, -1, 1'b0, 1'b0);
    run_txn(12'hABC, 32'h3000, 8'd0, 3'd2, BURST_INCR,  -1, 0, 5, -1, 1'b0, 1'b0);
    run_txn(12'h456, 32'h4000, 8'd7, 3'd3, BURST_INCR,  -1, 7, 0,  2, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    run_txn(12'h457, 32'h5000, 8'd1, 3'd3, BURST_INCR,  -1, 1, 0, -1, 1'b0, 1'b0);
    run_txn(12'h321, 32'hFFFF_FFF8, 8'd2, 3'd3, BURST_INCR, -1, 2, 1, -1, 1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      len   = 8'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      run_txn(12'($urandom), $urandom, len, 3'($urandom_range(0, 5)), burst,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len))) : -1,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len) + 1)) : int'(len),
              int'($urandom_range(0, 3)), -1, ($urandom_range(0, 7) == 0), 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
    chk("b_q_drained", 64'(b_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ID_W, 12, AXI ID width.
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axi_awid  in  ID_W  write address ID.
- s_axi_awaddr  in  ADDR_W  burst start address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3  log2 of bytes per beat.
- s_axi_awburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wid  in  ID_W  write data ID (AXI3).
- s_axi_wdata  in  DATA_W  write data.
- s_axi_wstrb  in  DATA_W/8  byte strobes.
- s_axi_wlast  in  1  last beat.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bid  out  ID_W  response ID.
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- mem_we  out  1  one-cycle write strobe per accepted beat.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  DATA_W  beat data.
- mem_wstrb  out  DATA_W/8  beat strobes.

Function
REQ-003 The block SHALL be a three-state FSM (IDLE, DATA, RESP) with one outstanding write transaction.
REQ-004 In IDLE: awready=1, wready=0, bvalid=0. On awvalid&awready it SHALL latch id, addr, len, size and burst, clear the beat counter and the error flag, and enter DATA.
REQ-005 In DATA: awready=0, wready=1. Each wvalid&wready SHALL produce, on the next cycle, mem_we=1 with that beat's address, data and strobes (latency 1).
REQ-006 Beat address SHALL be: FIXED, constant start address; INCR, previous + (1<<size), modulo 2^ADDR_W; WRAP, increment within the aligned window of (len+1)<<size bytes, returning to the window base at its top.
REQ-007 The error flag SHALL be set by any of: wid != latched id; wlast != (beat count == len); size > log2(DATA_W/8); burst == 11; WRAP with len not in {1,3,7,15}.
REQ-008 Reserved burst SHALL be treated as INCR; an oversize size SHALL step by DATA_W/8.
REQ-009 Completion is by beat count only: the accepting beat with count == len SHALL move the FSM to RESP, whatever the value of wlast.
REQ-010 In RESP: bvalid=1, bid=latched id, bresp=10 if the error flag is set, else 00, with awready=wready=0. bid and bresp SHALL stay stable until bready; on bvalid&bready the FSM SHALL enter IDLE.
REQ-011 W beats arriving before AW is accepted SHALL be stalled (wready=0), not dropped.
REQ-012 Minimum AW-to-AW spacing SHALL be len+3 cycles with zero wait states.

Reset
REQ-013 While rst=1, the FSM SHALL return to IDLE on the next edge; all outputs SHALL be 0 except awready, which is 1 from the first cycle after reset.
REQ-014 Reset mid-burst SHALL abandon the transaction: no further mem_we and no B response for it.

Structure
REQ-015 Package axi_wr_pkg SHALL hold the burst codes, response codes and FSM state enum.
REQ-016 The address-step logic SHALL be sub-module axi_burst_addr (inputs addr, size, len, burst; output next addr).

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- INCR, addr 0x1000, len 3, size 3, wlast on beat 3 -> mem_addr 0x1000/0x1008/0x1010/0x1018, bresp 00, bid = awid.
- WRAP, addr 0x1018, len 3, size 3 -> mem_addr 0x1018/0x1000/0x1008/0x1010, bresp 00.
- FIXED, addr 0x40, len 1, second beat wid differs -> two writes to 0x40, bresp 10.
- INCR, len 2, wlast asserted on beat 1 -> three mem_we pulses, bresp 10.
- bready held low 5 cycles -> bvalid and bid stable, awready 0 throughout.
- rst asserted after beat 1 of len 7 -> all outputs 0 next cycle, no bvalid; next AW accepted normally.
